mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the ALU/execute stage; consumes its registered result, destination register, store flag and memory address.
- Performs loads and stores through a valid/ready data-cache port and delivers the writeback value, rd and write-enable to the writeback stage.
- Non-memory ops pass through with one-cycle latency.
- Stalls upstream while a memory access is in flight.

Parameters:
- ADDR_W, 64, width of memory address.
- DATA_W, 64, width of data path and cache data bus (fixed 64; byte lanes = DATA_W/8).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- i_valid  input  1  execute-stage output valid.
- i_opcode  input  10  {funct3, opcode[6:0]}; loads 7'h03, stores 7'h23.
- i_pc  input  32  instruction PC.
- i_data  input  64  ALU result (non-mem) or store data (stores).
- i_mem_addr  input  ADDR_W  effective address (loads and stores).
- i_rd  input  5  destination register.
- i_wr_en  input  1  execute-stage write enable.
- i_flush  input  1  kill op presented this cycle.
- o_stall  output  1  upstream must hold its outputs.
- dc_req_valid  output  1  cache request valid.
- dc_req_ready  input  1  cache accepts request.
- dc_req_addr  output  ADDR_W  8-byte-aligned address.
- dc_req_we  output  1  1 = store.
- dc_req_wdata  output  64  lane-shifted store data.
- dc_req_be  output  8  byte enables.
- dc_resp_valid  input  1  response/ack.
- dc_resp_data  input  64  read data (full aligned doubleword).
- o_valid  output  1  writeback valid.
- o_pc  output  32  PC of the retiring op.
- o_data  output  64  writeback value.
- o_rd  output  5  destination register.
- o_wr_en  output  1  register-file write enable.
- o_misaligned  output  1  misaligned-access flag (MISALIGN_TRAP_EN only; tied to 0 otherwise).

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0, including dc_req_*, o_* and o_stall.
- States: IDLE, REQ, WAIT.
- IDLE, i_valid=1, i_flush=0, non-mem op: next cycle o_valid=1, o_data=i_data, o_rd=i_rd, o_wr_en=i_wr_en&&(i_rd!=0), o_pc=i_pc. Latency 1.
- IDLE, mem op accepted: latch opcode, addr, data, rd and pc; go to REQ; o_stall=1 combinationally in the same cycle.
- REQ: dc_req_valid=1; request fields held stable until dc_req_ready=1, then go to WAIT.
  - dc_req_addr = {addr[ADDR_W-1:3], 3'b0}.
  - Store size from funct3: sb 1, sh 2, sw 4, sd 8 bytes.
  - dc_req_be = size mask << addr[2:0].
  - dc_req_wdata = data << (8*addr[2:0]).
- WAIT: dc_req_valid=0; on dc_resp_valid go to IDLE. Next cycle o_valid=1 for one cycle.
  - Load: o_data = extracted value; o_wr_en=(rd!=0).
  - Store: o_data=0, o_rd=0, o_wr_en=0.
- Load extraction: shift = dc_resp_data >> (8*addr[2:0]).
  - lb(0)/lh(1)/lw(2) sign-extend 8/16/32 bits; ld(3) uses all 64.
  - lbu(4)/lhu(5)/lwu(6) zero-extend.
- o_stall = (state!=IDLE) || (IDLE && i_valid && !i_flush && mem op).
- o_valid is 0 in every cycle not listed above; o_data/o_rd hold their last value when o_valid=0.
- dc_resp_valid is ignored outside WAIT.
- dc_req_ready=1 in the first REQ cycle: accept and enter WAIT; minimum load/store latency is 3 cycles, accept to o_valid.
- i_flush kills only the op presented while IDLE; an op already in REQ/WAIT completes (it is older).
- Reset mid-access returns to IDLE immediately; the outstanding cache response is not awaited.
- Misalignment (without the macro): the address is used as-is; bytes beyond the doubleword are dropped (be truncated to 8 bits, data truncated).

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined: misaligned accesses are detected in IDLE (h: addr[0]; w: addr[1:0]; d: addr[2:0] nonzero). Such an access issues no cache request; next cycle o_valid=1, o_misaligned=1, o_wr_en=0.
- Undefined: no check; o_misaligned tied 0; truncation behaviour as above.

Decomposition:
- Package mem_pkg:
  - OPC_LOAD=7'h03, OPC_STORE=7'h23.
  - funct3 enum (LB, LH, LW, LD, LBU, LHU, LWU; SB, SH, SW, SD).
  - mem_state_t {IDLE, REQ, WAIT}.
  - Size-mask function.
- Sub-module load_align: combinational shift plus sign/zero extend (inputs resp_data, addr[2:0], funct3; output 64-bit value).

Test Plan:
- addi result: i_valid, opcode 10'h013, i_data=64'h5, rd=3 -> next cycle o_valid=1, o_data=5, o_rd=3, o_wr_en=1, o_stall=0.
- lb, addr 0x1003, resp_data 64'h00000000_80FF0000, ready=1 immediately, resp 1 cycle later -> o_data=64'hFFFF_FFFF_FFFF_FF80; lbu same -> 64'h80.
- sh, addr 0x2006, data 64'hABCD -> dc_req_addr=0x2000, be=8'hC0, wdata=64'hABCD_0000_0000_0000, we=1; o_wr_en=0 on completion.
- Backpressure: dc_req_ready low for 4 cycles on ld -> request fields stable, o_stall=1 throughout; ld rd=0 -> o_wr_en=0.
- Reset asserted during WAIT -> all outputs 0 asynchronously, state IDLE; a late dc_resp_valid is ignored.
- With MISALIGN_TRAP_EN: lw at 0x1002 -> no dc_req_valid, o_misaligned=1, o_wr_en=0; i_flush with a concurrent load in IDLE -> no request, o_valid stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: opcodes, funct3 encodings, FSM states and the byte-size mask shared by the memory stage.
package mem_pkg;
   localparam logic [6:0] OPC_LOAD  = 7'h03;
   localparam logic [6:0] OPC_STORE = 7'h23;
   typedef enum logic [2:0] {LB = 3'd0, LH, LW, LD, LBU, LHU, LWU} load_f3_t;
   typedef enum logic [2:0] {SB = 3'd0, SH, SW, SD} store_f3_t;
   typedef enum logic [1:0] {IDLE, REQ, WAIT} mem_state_t;
   // funct3[1:0] selects 1/2/4/8 bytes for both loads and stores
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      return sz == 2'd0 ? 8'h01 : sz == 2'd1 ? 8'h03 : sz == 2'd2 ? 8'h0F : 8'hFF;
   endfunction
endpackage

// File: rtl/load_align.sv
// load_align: shifts the addressed bytes of a cache doubleword down and sign/zero-extends them.
module load_align
   import mem_pkg::*;
(
   input  logic [63:0] resp_data,
   input  logic [2:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [63:0] value
);
   logic [63:0] sh;
   always_comb begin
      sh    = resp_data >> {addr_lo, 3'b000};
      value = funct3 == LB  ? {{56{sh[7]}}, sh[7:0]} :
              funct3 == LH  ? {{48{sh[15]}}, sh[15:0]} :
              funct3 == LW  ? {{32{sh[31]}}, sh[31:0]} :
              funct3 == LBU ? {56'd0, sh[7:0]} :
              funct3 == LHU ? {48'd0, sh[15:0]} :
              funct3 == LWU ? {32'd0, sh[31:0]} : sh;
   end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store stage between execute and writeback, driving a valid/ready data-cache port.
// Define MISALIGN_TRAP_EN to flag misaligned accesses instead of issuing them truncated.
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_valid,
   input  logic [9:0]          i_opcode,
   input  logic [31:0]         i_pc,
   input  logic [DATA_W-1:0]   i_data,
   input  logic [ADDR_W-1:0]   i_mem_addr,
   input  logic [4:0]          i_rd,
   input  logic                i_wr_en,
   input  logic                i_flush,
   output logic                o_stall,
   output logic                dc_req_valid,
   input  logic                dc_req_ready,
   output logic [ADDR_W-1:0]   dc_req_addr,
   output logic                dc_req_we,
   output logic [DATA_W-1:0]   dc_req_wdata,
   output logic [DATA_W/8-1:0] dc_req_be,
   input  logic                dc_resp_valid,
   input  logic [DATA_W-1:0]   dc_resp_data,
   output logic                o_valid,
   output logic [31:0]         o_pc,
   output logic [DATA_W-1:0]   o_data,
   output logic [4:0]          o_rd,
   output logic                o_wr_en,
   output logic                o_misaligned
);
   mem_state_t        state, next;
   logic [2:0]        op_f3;
   logic              op_st;
   logic [ADDR_W-1:0] op_addr;
   logic [DATA_W-1:0] op_data, ld_val;
   logic [4:0]        op_rd;
   logic [31:0]       op_pc;
   logic              is_mem, take, mis, accept, req;
   load_align u_align (.resp_data(dc_resp_data), .addr_lo(op_addr[2:0]), .funct3(op_f3), .value(ld_val));
   always_comb begin
      is_mem = i_opcode[6:0] == OPC_LOAD || i_opcode[6:0] == OPC_STORE;
      take   = state == IDLE && i_valid && !i_flush;
`ifdef MISALIGN_TRAP_EN
      mis    = i_opcode[8:7] == 2'd1 ? i_mem_addr[0] :
               i_opcode[8:7] == 2'd2 ? |i_mem_addr[1:0] :
               i_opcode[8:7] == 2'd3 ? |i_mem_addr[2:0] : 1'b0;
`else
      mis    = 1'b0;
`endif
      accept = take && is_mem && !mis;
      next   = state == IDLE ? (accept ? REQ : IDLE) :
               state == REQ  ? (dc_req_ready ? WAIT : REQ) :
                               (dc_resp_valid ? IDLE : WAIT);
      req    = state == REQ;
      // gated with reset so every output reads 0 while reset is held
      o_stall      = reset && (state != IDLE || (take && is_mem));
      dc_req_valid = req;
      dc_req_addr  = req ? {op_addr[ADDR_W-1:3], 3'b000} : '0;
      dc_req_we    = req && op_st;
      dc_req_be    = req ? size_mask(op_f3[1:0]) << op_addr[2:0] : '0;
      dc_req_wdata = req ? op_data << {op_addr[2:0], 3'b000} : '0;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         op_f3        <= '0;
         op_st        <= 1'b0;
         op_addr      <= '0;
         op_data      <= '0;
         op_rd        <= '0;
         op_pc        <= '0;
         o_valid      <= 1'b0;
         o_pc         <= '0;
         o_data       <= '0;
         o_rd         <= '0;
         o_wr_en      <= 1'b0;
         o_misaligned <= 1'b0;
      end else begin
         state        <= next;
         o_valid      <= 1'b0;
         o_wr_en      <= 1'b0;
         o_misaligned <= 1'b0;
         if (take && !is_mem) begin
            o_valid <= 1'b1;
            o_pc    <= i_pc;
            o_data  <= i_data;
            o_rd    <= i_rd;
            o_wr_en <= i_wr_en && i_rd != 5'd0;
         end else if (take && mis) begin
            o_valid      <= 1'b1;
            o_misaligned <= 1'b1;
            o_pc         <= i_pc;
            o_data       <= '0;
            o_rd         <= '0;
         end else if (accept) begin
            op_f3   <= i_opcode[9:7];
            op_st   <= i_opcode[6:0] == OPC_STORE;
            op_addr <= i_mem_addr;
            op_data <= i_data;
            op_rd   <= i_rd;
            op_pc   <= i_pc;
         end else if (state == WAIT && dc_resp_valid) begin
            o_valid <= 1'b1;
            o_pc    <= op_pc;
            o_data  <= op_st ? '0 : ld_val;
            o_rd    <= op_st ? 5'd0 : op_rd;
            o_wr_en <= !op_st && op_rd != 5'd0;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors with hand-computed results for mem_stage.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        i_valid = 1'b0, i_wr_en = 1'b0, i_flush = 1'b0;
   logic [9:0]  i_opcode = '0;
   logic [31:0] i_pc = '0;
   logic [63:0] i_data = '0, i_mem_addr = '0;
   logic [4:0]  i_rd = '0;
   logic        o_stall, dc_req_valid, dc_req_ready = 1'b0, dc_req_we, dc_resp_valid = 1'b0;
   logic [63:0] dc_req_addr, dc_req_wdata, dc_resp_data = '0, o_data;
   logic [7:0]  dc_req_be;
   logic        o_valid, o_wr_en, o_misaligned;
   logic [31:0] o_pc;
   logic [4:0]  o_rd;
   int          n_chk = 0, n_err = 0;

   mem_stage dut (
      .clk(clk), .reset(reset), .i_valid(i_valid), .i_opcode(i_opcode), .i_pc(i_pc),
      .i_data(i_data), .i_mem_addr(i_mem_addr), .i_rd(i_rd), .i_wr_en(i_wr_en),
      .i_flush(i_flush), .o_stall(o_stall), .dc_req_valid(dc_req_valid),
      .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
      .dc_req_wdata(dc_req_wdata), .dc_req_be(dc_req_be), .dc_resp_valid(dc_resp_valid),
      .dc_resp_data(dc_resp_data), .o_valid(o_valid), .o_pc(o_pc), .o_data(o_data),
      .o_rd(o_rd), .o_wr_en(o_wr_en), .o_misaligned(o_misaligned)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [9:0] opc, input logic [63:0] addr, input logic [63:0] data,
                        input logic [4:0] rd);
      i_valid    = 1'b1;
      i_opcode   = opc;
      i_mem_addr = addr;
      i_data     = data;
      i_rd       = rd;
      i_wr_en    = 1'b1;
      i_pc       = addr[31:0] ^ 32'hF000_0000;
   endtask

   // one memory op: accept, `hold` cycles of backpressure, then grant and a one-cycle response
   task automatic mem_op(input string tag, input logic [9:0] opc, input logic [63:0] addr,
                         input logic [63:0] data, input logic [63:0] resp, input logic [4:0] rd,
                         input int hold, input logic [63:0] e_addr, input logic [7:0] e_be,
                         input logic [63:0] e_wdata, input logic e_we);
      drive(opc, addr, data, rd);
      #1 chk({tag, "_stall_acc"}, o_stall, 1);
      tick();
      i_valid = 1'b0;
      for (int k = 0; k <= hold; k++) begin
         dc_req_ready = (k == hold);
         #1;
         chk({tag, "_req_valid"}, dc_req_valid, 1);
         chk({tag, "_req_addr"}, dc_req_addr, e_addr);
         chk({tag, "_req_be"}, dc_req_be, e_be);
         chk({tag, "_req_wdata"}, dc_req_wdata, e_wdata);
         chk({tag, "_req_we"}, dc_req_we, e_we);
         chk({tag, "_stall_req"}, o_stall, 1);
         tick();
      end
      dc_req_ready = 1'b0;
      chk({tag, "_wait_req"}, dc_req_valid, 0);
      chk({tag, "_wait_ov"}, o_valid, 0);
      dc_resp_data  = resp;
      dc_resp_valid = 1'b1;
      tick();
      dc_resp_valid = 1'b0;
      chk({tag, "_ov"}, o_valid, 1);
   endtask

   initial begin
      #3;
      chk("rst_ov", o_valid, 0);
      chk("rst_data", o_data, 0);
      chk("rst_rd", o_rd, 0);
      chk("rst_we", o_wr_en, 0);
      chk("rst_stall", o_stall, 0);
      chk("rst_req", dc_req_valid, 0);
      chk("rst_be", dc_req_be, 0);
      chk("rst_mis", o_misaligned, 0);
      tick();
      reset = 1'b1;
      tick();

      drive(10'h013, 64'h0, 64'h5, 5'd3);
      i_pc = 32'h100;
      #1 chk("addi_stall", o_stall, 0);
      tick();
      i_valid = 1'b0;
      chk("addi_ov", o_valid, 1);
      chk("addi_data", o_data, 64'h5);
      chk("addi_rd", o_rd, 3);
      chk("addi_we", o_wr_en, 1);
      chk("addi_pc", o_pc, 32'h100);
      tick();
      chk("addi_ov_drop", o_valid, 0);
      chk("addi_hold", o_data, 64'h5);

      drive(10'h033, 64'h0, 64'h77, 5'd0);
      tick();
      i_valid = 1'b0;
      chk("x0_ov", o_valid, 1);
      chk("x0_we", o_wr_en, 0);
      tick();

      mem_op("lb", 10'h003, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 5'd5, 0,
             64'h1000, 8'h08, 64'h0, 1'b0);
      chk("lb_data", o_data, 64'hFFFF_FFFF_FFFF_FF80);
      chk("lb_rd", o_rd, 5);
      chk("lb_we", o_wr_en, 1);
      chk("lb_pc", o_pc, 32'hF000_1003);
      tick();
      chk("lb_ov_drop", o_valid, 0);

      mem_op("lbu", 10'h203, 64'h1003, 64'h0, 64'h0000_0000_80FF_0000, 5'd5, 0,
             64'h1000, 8'h08, 64'h0, 1'b0);
      chk("lbu_data", o_data, 64'h80);

      mem_op("sh", 10'h0A3, 64'h2006, 64'hABCD, 64'hDEAD, 5'd7, 0,
             64'h2000, 8'hC0, 64'hABCD_0000_0000_0000, 1'b1);
      chk("sh_data", o_data, 0);
      chk("sh_rd", o_rd, 0);
      chk("sh_we", o_wr_en, 0);

      mem_op("ld", 10'h183, 64'h3008, 64'h0, 64'h1122_3344_5566_7788, 5'd0, 4,
             64'h3008, 8'hFF, 64'h0, 1'b0);
      chk("ld_data", o_data, 64'h1122_3344_5566_7788);
      chk("ld_we", o_wr_en, 0);

      mem_op("lw", 10'h103, 64'h4004, 64'h0, 64'h8000_0001_0000_0000, 5'd9, 1,
             64'h4000, 8'hF0, 64'h0, 1'b0);
      chk("lw_data", o_data, 64'hFFFF_FFFF_8000_0001);
      mem_op("lwu", 10'h303, 64'h4004, 64'h0, 64'h8000_0001_0000_0000, 5'd9, 0,
             64'h4000, 8'hF0, 64'h0, 1'b0);
      chk("lwu_data", o_data, 64'h8000_0001);
      mem_op("lh", 10'h083, 64'h4002, 64'h0, 64'h0000_0000_BEEF_0000, 5'd9, 0,
             64'h4000, 8'h0C, 64'h0, 1'b0);
      chk("lh_data", o_data, 64'hFFFF_FFFF_FFFF_BEEF);
      mem_op("sb", 10'h023, 64'h5005, 64'h1FF, 64'h0, 5'd4, 0,
             64'h5000, 8'h20, 64'h0001_FF00_0000_0000, 1'b1);
      chk("sb_we", o_wr_en, 0);
      tick();

`ifdef MISALIGN_TRAP_EN
      drive(10'h103, 64'h1002, 64'h0, 5'd6);
      tick();
      i_valid = 1'b0;
      chk("mis_req", dc_req_valid, 0);
      chk("mis_ov", o_valid, 1);
      chk("mis_flag", o_misaligned, 1);
      chk("mis_we", o_wr_en, 0);
      tick();
      chk("mis_flag_drop", o_misaligned, 0);
      chk("mis_stall", o_stall, 0);
`else
      mem_op("sd_mis", 10'h1A3, 64'h6003, 64'h0102_0304_0506_0708, 64'h0, 5'd1, 0,
             64'h6000, 8'hF8, 64'h0405_0607_0800_0000, 1'b1);
      chk("sd_mis_flag", o_misaligned, 0);
      tick();
`endif

      drive(10'h003, 64'h1000, 64'h0, 5'd2);
      i_flush = 1'b1;
      #1 chk("flush_stall", o_stall, 0);
      tick();
      i_valid = 1'b0;
      i_flush = 1'b0;
      chk("flush_req", dc_req_valid, 0);
      chk("flush_ov", o_valid, 0);
      tick();
      chk("flush_req2", dc_req_valid, 0);

      drive(10'h183, 64'h7000, 64'h0, 5'd8);
      tick();
      i_valid = 1'b0;
      dc_req_ready = 1'b1;
      tick();
      dc_req_ready = 1'b0;
      chk("rwait_req", dc_req_valid, 0);
      chk("rwait_stall", o_stall, 1);
      #2 reset = 1'b0;
      #1;
      chk("rwait_stall0", o_stall, 0);
      chk("rwait_data0", o_data, 0);
      chk("rwait_pc0", o_pc, 0);
      chk("rwait_rd0", o_rd, 0);
      dc_resp_data  = 64'h55;
      dc_resp_valid = 1'b1;
      tick();
      reset = 1'b1;
      tick();
      chk("late_ov", o_valid, 0);
      chk("late_req", dc_req_valid, 0);
      chk("late_stall", o_stall, 0);
      dc_resp_valid = 1'b0;
      tick();
      chk("late_ov2", o_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
